ad9361_init_sequencer: RTL and testbench

Command-list sequencer that sits directly upstream of the 24-bit SPI configuration master. It walks a command ROM of register writes, read-polls with mask/compare and timed delays. Each access is packed into a 24-bit SPI frame and issued over the master's DV/Ready handshake. Used at power-up and on re-calibration to bring the AD9361 to a known state without software.

---
 rtl/ad9361_spi_pkg.sv | 39 +++
 rtl/ad9361_cmd_timer.sv | 28 ++
 rtl/ad9361_init_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_ad9361_init_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad9361_spi_pkg.sv
// Shared definitions for the AD9361 init sequencer: opcodes, command-word
// field positions, FSM state encoding and SPI frame packing.
package ad9361_spi_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_POLL  = 2'b01,
    OP_DELAY = 2'b10,
    OP_END   = 2'b11
  } op_e;

  localparam int unsigned CMD_OP_LSB   = 30;
  localparam int unsigned CMD_ADDR_LSB = 20;
  localparam int unsigned CMD_DATA_LSB = 12;
  localparam int unsigned CMD_MASK_LSB = 4;
  localparam int unsigned REG_ADDR_W   = 10;
  localparam int unsigned DLY_W        = 30;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_DELAY,
    ST_GAP,
    ST_DONE,
    ST_ERROR
  } seq_state_e;

  // {W, 3'b000, 2'b00, addr[9:0], data[7:0]}
  function automatic logic [23:0] pack_frame(input logic wr,
                                             input logic [REG_ADDR_W-1:0] addr,
                                             input logic [7:0] data);
    return {wr, 3'b000, 2'b00, addr, data};
  endfunction

endpackage

// File: rtl/ad9361_cmd_timer.sv
// Loadable 30-bit down-counter shared by DELAY commands and the poll gap.
module ad9361_cmd_timer
  import ad9361_spi_pkg::*;
(
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Load,
  input  logic [DLY_W-1:0] i_Count,
  output logic             o_Busy,
  output logic             o_Zero
);

  logic [DLY_W-1:0] cnt_q;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      cnt_q <= '0;
    end else if (i_Load) begin
      cnt_q <= i_Count;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign o_Busy = (cnt_q != '0);
  assign o_Zero = (cnt_q == '0);

endmodule

// File: rtl/ad9361_init_sequencer.sv
// Command-ROM sequencer driving the 24-bit SPI configuration master:
// register writes, masked read-polls with retry gap, and timed delays.
module ad9361_init_sequencer
  import ad9361_spi_pkg::*;
#(
  parameter int unsigned ROM_ADDR_W = 8,
  parameter int unsigned POLL_MAX   = 1023,
  parameter int unsigned POLL_GAP   = 100
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_Start,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic                  o_Error,
  output logic [ROM_ADDR_W-1:0] o_Err_Index,
  output logic [ROM_ADDR_W-1:0] o_Cmd_Addr,
  input  logic [31:0]           i_Cmd_Word,
  output logic [23:0]           o_TX_Byte,
  output logic                  o_TX_DV,
  input  logic                  i_TX_Ready,
  input  logic                  i_RX_DV,
  input  logic [7:0]            i_RX_Byte
);

  localparam int unsigned ATT_W = $clog2(POLL_MAX + 1);
  localparam logic [ATT_W-1:0] POLL_LAST = ATT_W'(POLL_MAX - 1);
  localparam logic [DLY_W-1:0] GAP_LOAD  = DLY_W'(POLL_GAP);

  seq_state_e            state_q;
  op_e                   op_q;
  logic [REG_ADDR_W-1:0] reg_addr_q;
  logic [7:0]            data_q;
  logic [7:0]            mask_q;
  logic [ROM_ADDR_W-1:0] addr_q;
  logic [ROM_ADDR_W-1:0] err_idx_q;
  logic [ATT_W-1:0]      attempt_q;
  logic [23:0]           tx_byte_q;
  logic                  tx_dv_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  error_q;
  logic                  rx_seen_q;
  logic [7:0]            rx_q;

  op_e                   cmd_op;
  logic [DLY_W-1:0]      cmd_dly;
  logic                  addr_last;
  logic [7:0]            rx_eff;
  logic                  rx_seen_eff;
  logic                  poll_pass;
  logic                  xfer_exit;
  logic                  tmr_load;
  logic [DLY_W-1:0]      tmr_count;
  logic                  tmr_busy;
  logic                  tmr_zero;

  assign cmd_op    = op_e'(i_Cmd_Word[CMD_OP_LSB +: 2]);
  assign cmd_dly   = i_Cmd_Word[DLY_W-1:0];
  assign addr_last = (addr_q == '1);

  // Read data arriving with the ready return is used in that same cycle.
  assign rx_eff      = i_RX_DV ? i_RX_Byte : rx_q;
  assign rx_seen_eff = rx_seen_q | i_RX_DV;
  assign poll_pass   = (((rx_eff ^ data_q) & mask_q) == 8'h00);
  assign xfer_exit   = i_TX_Ready && ((op_q == OP_WRITE) || rx_seen_eff);

  always_comb begin
    tmr_load  = 1'b0;
    tmr_count = '0;
    if (state_q == ST_DECODE && cmd_op == OP_DELAY && cmd_dly != '0) begin
      tmr_load  = 1'b1;
      tmr_count = cmd_dly;
    end else if (state_q == ST_WAIT_DONE && xfer_exit && op_q == OP_POLL && !poll_pass) begin
      tmr_load  = 1'b1;
      tmr_count = GAP_LOAD;
    end
  end

  ad9361_cmd_timer u_timer (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Load  (tmr_load),
    .i_Count (tmr_count),
    .o_Busy  (tmr_busy),
    .o_Zero  (tmr_zero)
  );

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_WRITE;
      reg_addr_q <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      addr_q     <= '0;
      err_idx_q  <= '0;
      attempt_q  <= '0;
      tx_byte_q  <= '0;
      tx_dv_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      rx_seen_q  <= 1'b0;
      rx_q       <= '0;
    end else begin
      tx_dv_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_Start) begin
            error_q   <= 1'b0;
            addr_q    <= '0;
            attempt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_FETCH;
          end
        end
        ST_FETCH: state_q <= ST_DECODE;
        ST_DECODE: begin
          op_q       <= cmd_op;
          reg_addr_q <= i_Cmd_Word[CMD_ADDR_LSB +: REG_ADDR_W];
          data_q     <= i_Cmd_Word[CMD_DATA_LSB +: 8];
          mask_q     <= i_Cmd_Word[CMD_MASK_LSB +: 8];
          case (cmd_op)
            OP_WRITE, OP_POLL: state_q <= ST_ISSUE;
            OP_DELAY: begin
              if (cmd_dly != '0) begin
                state_q <= ST_DELAY;
              end else if (addr_last) begin
                state_q <= ST_DONE;
              end else begin
                addr_q  <= addr_q + 1'b1;
                state_q <= ST_FETCH;
              end
            end
            default: state_q <= ST_DONE;
          endcase
        end
        ST_ISSUE: begin
          if (i_TX_Ready) begin
            tx_dv_q   <= 1'b1;
            tx_byte_q <= pack_frame(op_q == OP_WRITE, reg_addr_q,
                                    (op_q == OP_WRITE) ? data_q : 8'h00);
            rx_seen_q <= 1'b0;
            state_q   <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          if (i_RX_DV) begin
            rx_seen_q <= 1'b1;
            rx_q      <= i_RX_Byte;
          end
          if (!i_TX_Ready) state_q <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (i_RX_DV) begin
            rx_seen_q <= 1'b1;
            rx_q      <= i_RX_Byte;
          end
          if (xfer_exit) begin
            if (op_q == OP_WRITE || poll_pass) begin
              attempt_q <= '0;
              if (addr_last) begin
                state_q <= ST_DONE;
              end else begin
                addr_q  <= addr_q + 1'b1;
                state_q <= ST_FETCH;
              end
            end else if (attempt_q == POLL_LAST) begin
              state_q <= ST_ERROR;
            end else begin
              attempt_q <= attempt_q + 1'b1;
              state_q   <= ST_GAP;
            end
          end
        end
        ST_DELAY: begin
          if (tmr_zero) begin
            if (addr_last) begin
              state_q <= ST_DONE;
            end else begin
              addr_q  <= addr_q + 1'b1;
              state_q <= ST_FETCH;
            end
          end
        end
        ST_GAP: if (!tmr_busy) state_q <= ST_ISSUE;
        ST_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        ST_ERROR: begin
          error_q   <= 1'b1;
          err_idx_q <= addr_q;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_Busy      = busy_q;
  assign o_Done      = done_q;
  assign o_Error     = error_q;
  assign o_Err_Index = err_idx_q;
  assign o_Cmd_Addr  = addr_q;
  assign o_TX_Byte   = tx_byte_q;
  assign o_TX_DV     = tx_dv_q;

endmodule

// File: tb/tb_ad9361_init_sequencer.sv
// Self-checking bench: ROM model, SPI master model and a frame scoreboard.
module tb_ad9361_init_sequencer;

  localparam int unsigned AW   = 4;
  localparam int unsigned PMAX = 4;
  localparam int unsigned PGAP = 20;

  logic          clk = 1'b0;
  logic          i_Rst;
  logic          i_Start;
  logic          o_Busy, o_Done, o_Error;
  logic [AW-1:0] o_Err_Index, o_Cmd_Addr;
  logic [31:0]   rom_q;
  logic [23:0]   o_TX_Byte;
  logic          o_TX_DV;
  logic          tx_ready;
  logic          rx_dv;
  logic [7:0]    rx_byte;

  logic [31:0]   rom [16];
  logic [23:0]   exp_q [$];
  logic [7:0]    resp_q [$];
  logic [7:0]    resp_dflt;
  int unsigned   ftimes [$];
  int unsigned   cyc = 0;
  int            n_cmp = 0;
  int            n_err = 0;
  int            n_frames = 0;
  int unsigned   t_start;
  bit            hold_low = 1'b0;
  bit            pend = 1'b0;
  bit            rd_frame = 1'b0;
  int            bcnt = 0;

  ad9361_init_sequencer #(.ROM_ADDR_W(AW), .POLL_MAX(PMAX), .POLL_GAP(PGAP)) dut (
    .i_Clk       (clk),
    .i_Rst       (i_Rst),
    .i_Start     (i_Start),
    .o_Busy      (o_Busy),
    .o_Done      (o_Done),
    .o_Error     (o_Error),
    .o_Err_Index (o_Err_Index),
    .o_Cmd_Addr  (o_Cmd_Addr),
    .i_Cmd_Word  (rom_q),
    .o_TX_Byte   (o_TX_Byte),
    .o_TX_DV     (o_TX_DV),
    .i_TX_Ready  (tx_ready),
    .i_RX_DV     (rx_dv),
    .i_RX_Byte   (rx_byte)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_q <= rom[o_Cmd_Addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] c_wr(input logic [9:0] a, input logic [7:0] d);
    return {2'b00, a, d, 8'h00, 4'h0};
  endfunction
  function automatic logic [31:0] c_poll(input logic [9:0] a, input logic [7:0] e, input logic [7:0] m);
    return {2'b01, a, e, m, 4'h0};
  endfunction
  function automatic logic [31:0] c_dly(input logic [29:0] n);
    return {2'b10, n};
  endfunction
  localparam logic [31:0] C_END = 32'hC000_0000;

  // SPI master: ready drops one cycle after DV, returns 6 cycles later with read data.
  always @(negedge clk) begin
    if (i_Rst) begin
      tx_ready = 1'b1; pend = 1'b0; bcnt = 0; rx_dv = 1'b0; rx_byte = 8'h00;
    end else begin
      rx_dv = 1'b0;
      if (pend) begin
        pend = 1'b0; tx_ready = 1'b0; bcnt = 6;
      end else if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) begin
          tx_ready = 1'b1;
          if (rd_frame) begin
            rx_dv   = 1'b1;
            rx_byte = (resp_q.size() > 0) ? resp_q.pop_front() : resp_dflt;
          end
        end
      end else begin
        tx_ready = !hold_low;
      end
      if (o_TX_DV) begin
        pend = 1'b1;
        rd_frame = !o_TX_Byte[23];
      end
    end
  end

  // Scoreboard consumer
  always @(negedge clk) begin
    if (!i_Rst && o_TX_DV) begin
      n_frames++;
      ftimes.push_back(cyc);
      if (exp_q.size() == 0) check("unexpected_frame", 32'(o_TX_Byte), 32'hFFFF_FFFF);
      else check("frame", 32'(o_TX_Byte), 32'(exp_q.pop_front()));
    end
  end

  task automatic rom_clear();
    for (int i = 0; i < 16; i++) rom[i] = C_END;
    ftimes.delete();
    resp_q.delete();
    n_frames = 0;
  endtask

  task automatic start_pulse();
    i_Start = 1'b1;
    @(negedge clk);
    i_Start = 1'b0;
    t_start = cyc;
  endtask

  task automatic wait_idle(input int limit, output bit saw_done);
    bit to;
    saw_done = 1'b0;
    to = 1'b1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (o_Done) saw_done = 1'b1;
      if (!o_Busy) begin to = 1'b0; break; end
    end
    check("seq_timeout", 32'(to), 0);
    @(negedge clk);
    check("done_one_cycle", 32'(o_Done), 0);
  endtask

  task automatic run_seq(input int limit, output bit saw_done);
    start_pulse();
    check("busy_after_start", 32'(o_Busy), 1);
    wait_idle(limit, saw_done);
  endtask

  bit done_seen;
  bit to_w;

  initial begin
    i_Rst = 1'b1; i_Start = 1'b0; resp_dflt = 8'h00;
    rom_clear();
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(o_Busy), 0);
    check("rst_done", 32'(o_Done), 0);
    check("rst_error", 32'(o_Error), 0);
    check("rst_addr", 32'(o_Cmd_Addr), 0);
    check("rst_txdv", 32'(o_TX_DV), 0);
    check("rst_txbyte", 32'(o_TX_Byte), 0);
    i_Rst = 1'b0;
    repeat (2) @(negedge clk);

    // single write
    rom_clear();
    rom[0] = c_wr(10'h3DF, 8'h01);
    exp_q.push_back(24'h83DF01);
    run_seq(500, done_seen);
    check("t1_done", 32'(done_seen), 1);
    check("t1_error", 32'(o_Error), 0);
    check("t1_busy", 32'(o_Busy), 0);
    check("t1_frames", n_frames, 1);

    // poll passes on third read
    rom_clear();
    rom[0] = c_poll(10'h016, 8'h00, 8'h01);
    resp_q.push_back(8'h03); resp_q.push_back(8'h03); resp_q.push_back(8'h02);
    repeat (3) exp_q.push_back(24'h001600);
    run_seq(1000, done_seen);
    check("t2_done", 32'(done_seen), 1);
    check("t2_frames", n_frames, 3);
    for (int i = 1; i < 3 && i < ftimes.size(); i++)
      check("t2_gap_ge_pollgap", 32'(ftimes[i] - ftimes[i-1] >= PGAP), 1);

    // poll timeout at ROM index 1
    rom_clear();
    rom[0] = c_wr(10'h010, 8'hA5);
    rom[1] = c_poll(10'h016, 8'h00, 8'h01);
    resp_dflt = 8'h01;
    exp_q.push_back(24'h8010A5);
    repeat (PMAX) exp_q.push_back(24'h001600);
    run_seq(1000, done_seen);
    check("t3_no_done", 32'(done_seen), 0);
    check("t3_error", 32'(o_Error), 1);
    check("t3_err_index", 32'(o_Err_Index), 1);
    check("t3_frames", n_frames, PMAX + 1);
    resp_dflt = 8'h00;

    // delay, write, zero delay
    rom_clear();
    rom[0] = c_dly(30'd50);
    rom[1] = c_wr(10'h002, 8'h5E);
    rom[2] = c_dly(30'd0);
    exp_q.push_back(24'h80025E);
    start_pulse();
    check("t4_error_cleared", 32'(o_Error), 0);
    wait_idle(500, done_seen);
    check("t4_done", 32'(done_seen), 1);
    check("t4_frames", n_frames, 1);
    if (ftimes.size() > 0) check("t4_delay_ge_50", 32'(ftimes[0] - t_start >= 51), 1);

    // ready held low, then start pulsed while busy
    rom_clear();
    rom[0] = c_wr(10'h3DF, 8'h01);
    exp_q.push_back(24'h83DF01);
    hold_low = 1'b1;
    repeat (2) @(negedge clk);
    start_pulse();
    repeat (20) @(negedge clk);
    check("t5_no_dv_while_low", n_frames, 0);
    check("t5_busy_hold", 32'(o_Busy), 1);
    hold_low = 1'b0;
    to_w = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (n_frames > 0) begin to_w = 1'b0; break; end
    end
    check("t5_frame_timeout", 32'(to_w), 0);
    @(negedge clk);
    i_Start = 1'b1;
    @(negedge clk);
    i_Start = 1'b0;
    wait_idle(500, done_seen);
    check("t5_done", 32'(done_seen), 1);
    check("t5_frames", n_frames, 1);

    // async reset in WAIT_DONE, then replay
    rom_clear();
    rom[0] = c_wr(10'h3DF, 8'h01);
    exp_q.push_back(24'h83DF01);
    start_pulse();
    to_w = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (n_frames > 0) begin to_w = 1'b0; break; end
    end
    check("t6_frame_timeout", 32'(to_w), 0);
    repeat (3) @(negedge clk);
    i_Rst = 1'b1;
    #1;
    check("t6_rst_busy", 32'(o_Busy), 0);
    check("t6_rst_addr", 32'(o_Cmd_Addr), 0);
    check("t6_rst_txbyte", 32'(o_TX_Byte), 0);
    check("t6_rst_error", 32'(o_Error), 0);
    @(negedge clk);
    i_Rst = 1'b0;
    @(negedge clk);
    n_frames = 0;
    exp_q.push_back(24'h83DF01);
    run_seq(500, done_seen);
    check("t6_replay_done", 32'(done_seen), 1);
    check("t6_replay_frames", n_frames, 1);

    // address wrap: full ROM of writes, no END
    rom_clear();
    for (int i = 0; i < 16; i++) begin
      rom[i] = c_wr(10'(i * 3 + 1), 8'(8'h40 + i));
      exp_q.push_back({1'b1, 5'b00000, 10'(i * 3 + 1), 8'(8'h40 + i)});
    end
    run_seq(2000, done_seen);
    check("t7_wrap_done", 32'(done_seen), 1);
    check("t7_frames", n_frames, 16);
    check("t7_error", 32'(o_Error), 0);

    check("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
